text_stream_framer: RTL and testbench

Upstream stage of the keyword block checker: accepts a raw ASCII byte stream with a valid/ready handshake and emits a normalised character stream the checker consumes directly. Normalisation maps all whitespace to a single space, folds `A`–`Z` to lowercase, drops non-printables and leading blanks, and appends a closing space at end of text so the checker always sees the last word terminated. An internal FIFO decouples producer and consumer. A saturating word counter is maintained for status.

---
 rtl/text_stream_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/text_stream_framer.sv | 115 +++++++++++
 tb/tb_text_stream_framer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_stream_pkg.sv
// Shared constants, byte classification and FSM state type for the text stream framer.
package text_stream_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;

    typedef enum logic [1:0] {
        CLS_WS,
        CLS_DROP,
        CLS_CHAR
    } byte_class_e;

    typedef enum logic [1:0] {
        IDLE,
        WORD,
        GAP,
        FLUSH
    } framer_state_e;

    function automatic byte_class_e classify(input logic [7:0] b);
        if (b == ASCII_SPACE || b == ASCII_TAB || b == ASCII_LF || b == ASCII_CR)
            return CLS_WS;
        if (b < ASCII_SPACE || b >= ASCII_DEL)
            return CLS_DROP;
        return CLS_CHAR;
    endfunction

    function automatic logic [7:0] fold_case(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO; head reads as 0x00 while empty so out_data is defined after reset.
module sync_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/text_stream_framer.sv
// Normalises a raw ASCII byte stream into lowercase words separated by single spaces,
// buffering the result in a small FIFO and counting terminated words.
module text_stream_framer
    import text_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             frame_done,
    output logic [CNT_W-1:0] word_count
);

    framer_state_e    state_q, state_d;
    logic             run_q;
    logic             done_q, done_d;
    logic [CNT_W-1:0] wc_q, wc_d;
    logic             wc_inc;
    logic             accept;
    logic             push;
    logic [7:0]       push_data;
    logic             fifo_full, fifo_empty;
    byte_class_e      cls;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data)
    );

    // run_q holds in_ready low while reset is asserted without looking at the reset pin.
    assign in_ready   = run_q && !fifo_full && (state_q != FLUSH);
    assign accept     = in_valid && in_ready;
    assign out_valid  = !fifo_empty;
    assign frame_done = done_q;
    assign word_count = wc_q;

    always_comb begin
        cls       = classify(in_data);
        state_d   = state_q;
        push      = 1'b0;
        push_data = fold_case(in_data);
        wc_inc    = 1'b0;
        done_d    = 1'b0;

        if (state_q == FLUSH) begin
            if (!fifo_full) begin
                push      = 1'b1;
                push_data = ASCII_SPACE;
                wc_inc    = 1'b1;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
        end else if (accept) begin
            case (state_q)
                WORD: begin
                    if (cls == CLS_CHAR) begin
                        push = 1'b1;
                    end else if (cls == CLS_WS) begin
                        push      = 1'b1;
                        push_data = ASCII_SPACE;
                        wc_inc    = 1'b1;
                        state_d   = GAP;
                    end
                end
                default: begin
                    if (cls == CLS_CHAR) begin
                        push    = 1'b1;
                        state_d = WORD;
                    end
                end
            endcase

            // A frame ending mid-word still owes the checker its closing space.
            if (in_last) begin
                if (state_d == WORD) begin
                    state_d = FLUSH;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        end

        wc_d = (wc_inc && wc_q != '1) ? wc_q + CNT_W'(1) : wc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            done_q  <= done_d;
            wc_q    <= wc_d;
        end
    end

endmodule

// File: tb/tb_text_stream_framer.sv
// Scenario bench for text_stream_framer with a scoreboard of expected output characters.
`timescale 1ns/1ps
module tb_text_stream_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  in_data;
    logic        out_valid, out_ready, frame_done;
    logic [7:0]  out_data;
    logic [15:0] word_count;

    logic        s_valid, s_last, s_ready, s_ovalid, s_done;
    logic [7:0]  s_data, s_odata;
    logic [3:0]  s_wc;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int wc_exp = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;

    always #5 clk = ~clk;

    text_stream_framer #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .frame_done(frame_done), .word_count(word_count)
    );

    text_stream_framer #(.DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(s_valid), .in_data(s_data), .in_last(s_last), .in_ready(s_ready),
        .out_valid(s_ovalid), .out_data(s_odata), .out_ready(1'b1),
        .frame_done(s_done), .word_count(s_wc)
    );

    // Consumer side: every character taken is checked against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_done) frames++;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_data: got %h, scoreboard empty", out_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (out_data !== exp_byte) begin
                        errors++;
                        $display("FAIL out_data: got %h, expected %h", out_data, exp_byte);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b, expected 1 for byte %h", in_ready, b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d chars still expected, expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL rst_out_data: got %h, expected 00", out_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b, expected 0", frame_done); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL rst_word_count: got %0d, expected 0", word_count); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_basic();
        int f0 = frames;
        out_ready = 1'b1;
        push_exp("begin end ");
        send_str("Begin\tEND", 1'b1);
        wait_drain();
        wc_exp += 2;
        checks++; if (word_count !== 16'(wc_exp)) begin errors++; $display("FAIL basic_wc: got %0d, expected %0d", word_count, wc_exp); end
        checks++; if (frames - f0 != 1) begin errors++; $display("FAIL basic_frames: got %0d, expected 1", frames - f0); end
    endtask

    task automatic test_blanks();
        int f0 = frames;
        push_exp("ab c ");
        send_str("  \n ab  c", 1'b1);
        wait_drain();
        wc_exp += 2;
        checks++; if (word_count !== 16'(wc_exp)) begin errors++; $display("FAIL blanks_wc: got %0d, expected %0d", word_count, wc_exp); end
        checks++; if (frames - f0 != 1) begin errors++; $display("FAIL blanks_frames: got %0d, expected 1", frames - f0); end
    endtask

    task automatic test_drop();
        int f0 = frames;
        push_exp("ab ");
        send_byte(8'h61, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h7F, 1'b1);
        wait_drain();
        wc_exp += 1;
        checks++; if (word_count !== 16'(wc_exp)) begin errors++; $display("FAIL drop_wc: got %0d, expected %0d", word_count, wc_exp); end
        checks++; if (frames - f0 != 1) begin errors++; $display("FAIL drop_frames: got %0d, expected 1", frames - f0); end
    endtask

    task automatic test_backpressure();
        int f0 = frames;
        out_ready = 1'b0;
        push_exp("abcdef ");
        send_str("abcd", 1'b0);
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready_full: got %b, expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, expected 1", out_valid); end
        checks++; if (out_data !== 8'h61) begin errors++; $display("FAIL bp_head: got %h, expected 61", out_data); end
        repeat (3) @(posedge clk); #1;
        checks++; if (out_data !== 8'h61) begin errors++; $display("FAIL bp_head_stable: got %h, expected 61", out_data); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready_held: got %b, expected 0", in_ready); end
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_ready_full_pop: got %b, expected 0", in_ready); end
        send_str("ef", 1'b1);
        wait_drain();
        wc_exp += 1;
        checks++; if (word_count !== 16'(wc_exp)) begin errors++; $display("FAIL bp_wc: got %0d, expected %0d", word_count, wc_exp); end
        checks++; if (frames - f0 != 1) begin errors++; $display("FAIL bp_frames: got %0d, expected 1", frames - f0); end
    endtask

    task automatic test_trailing_space();
        int f0 = frames;
        push_exp("x ");
        send_str("x ", 1'b1);
        wait_drain();
        wc_exp += 1;
        checks++; if (word_count !== 16'(wc_exp)) begin errors++; $display("FAIL trail_wc: got %0d, expected %0d", word_count, wc_exp); end
        checks++; if (frames - f0 != 1) begin errors++; $display("FAIL trail_frames: got %0d, expected 1", frames - f0); end
        f0 = frames;
        push_exp("y ");
        send_str("Y", 1'b1);
        wait_drain();
        wc_exp += 1;
        checks++; if (word_count !== 16'(wc_exp)) begin errors++; $display("FAIL next_wc: got %0d, expected %0d", word_count, wc_exp); end
        checks++; if (frames - f0 != 1) begin errors++; $display("FAIL next_frames: got %0d, expected 1", frames - f0); end
    endtask

    task automatic test_async_reset();
        int f0;
        out_ready = 1'b0;
        send_str("pqr", 1'b0);
        #3;
        reset = 1'b0;
        #1;
        exp_q.delete();
        wc_exp = 0;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL arst_out_valid: got %b, expected 0", out_valid); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL arst_word_count: got %0d, expected 0", word_count); end
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL arst_in_ready: got %b, expected 0", in_ready); end
        checks++; if (out_data !== 8'h00)   begin errors++; $display("FAIL arst_out_data: got %h, expected 00", out_data); end
        @(negedge clk);
        f0 = frames;
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        checks++; if (frames != f0)      begin errors++; $display("FAIL arst_no_frame: got %0d, expected 0", frames - f0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_empty: got %b, expected 0", out_valid); end
        push_exp("q ");
        send_str("q", 1'b1);
        wait_drain();
        wc_exp += 1;
        checks++; if (word_count !== 16'(wc_exp)) begin errors++; $display("FAIL arst_wc: got %0d, expected %0d", word_count, wc_exp); end
        checks++; if (frames - f0 != 1) begin errors++; $display("FAIL arst_frames: got %0d, expected 1", frames - f0); end
    endtask

    task automatic test_saturation();
        s_valid = 1'b1;
        for (int i = 0; i < 34; i++) begin
            s_data = (i % 2 == 0) ? 8'h61 : 8'h20;
            @(posedge clk); #1;
            if (i == 27) begin
                checks++; if (s_wc !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d, expected 14", s_wc); end
            end
            if (i == 29) begin
                checks++; if (s_wc !== 4'd15) begin errors++; $display("FAIL sat_15: got %0d, expected 15", s_wc); end
            end
        end
        s_valid = 1'b0;
        checks++; if (s_wc !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d, expected 15", s_wc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanks();
        test_drop();
        test_backpressure();
        test_trailing_space();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
